// File: rtl/arm_mem_pkg.sv
// Shared types and default constants for the wait-state data memory.
// State encoding is fixed so that debug tools can decode the raw state bits.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DEPTH     = 64;
  localparam int DEF_BASE_ADDR = 32'h400;
  localparam int DEF_LATENCY   = 2;

  // Wide enough for the largest legal LATENCY (15).
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read, no reset.
// Contents are undefined until written.
module mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_wait.sv
// Word memory with a fixed number of wait states per access; ready pulses once per access.
// The requester holds w_en/r_en/address/data until ready; the write and read sample happen on the WAIT->DONE edge.
module data_mem_wait
  import arm_mem_pkg::*;
#(
  parameter int          DATA_W    = DEF_DATA_W,
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter int          DEPTH     = DEF_DEPTH,
  parameter int unsigned BASE_ADDR = DEF_BASE_ADDR,
  parameter int          LATENCY   = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] out,
  output logic              ready,
  output logic              addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  idx;
  logic              out_of_range;
  logic              finish;
  logic              mem_we;
  logic [DATA_W-1:0] rd_word;

  // Byte offset from the window base; the two low bits select a byte and are dropped.
  assign offset       = address - ADDR_W'(BASE_ADDR);
  assign idx          = offset[IDX_W+1:2];
  assign out_of_range = (address < ADDR_W'(BASE_ADDR)) ||
                        ((offset >> 2) >= ADDR_W'(DEPTH));

  assign finish = (state == WAIT) && (cnt == '0);
  // A reset landing on the completing edge aborts the access, including its write.
  assign mem_we = finish && w_en && !out_of_range && !rst;

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (idx),
    .wdata (data),
    .raddr (idx),
    .rdata (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      out      <= '0;
      ready    <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      ready    <= 1'b0;
      addr_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (w_en || r_en) begin
            state <= WAIT;
            cnt   <= LAT_M1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state    <= DONE;
            ready    <= 1'b1;
            addr_err <= out_of_range;
            // Write wins over read: out only moves for a pure read.
            if (r_en && !w_en) out <= out_of_range ? '0 : rd_word;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/data_mem_wait.md
DATA_MEM_WAIT -- requirements
Module: data_mem_wait

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width in bits.
REQ-003 SHALL have parameter DEPTH, default 64, number of words stored.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h400, byte address of word 0.
REQ-005 SHALL have parameter LATENCY, default 2, wait cycles per access; legal range 1..15.
REQ-006 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port w_en  input  1  write request.
REQ-009 SHALL have port r_en  input  1  read request.
REQ-010 SHALL have port address  input  ADDR_W  byte address.
REQ-011 SHALL have port data  input  DATA_W  write data.
REQ-012 SHALL have port out  output  DATA_W  registered read data.
REQ-013 SHALL have port ready  output  1  one-cycle access-complete strobe; pipeline stall = (w_en|r_en) & ~ready.
REQ-014 SHALL have port addr_err  output  1  out-of-range flag, valid only while ready=1.

Function
REQ-015 SHALL compute word index = (address - BASE_ADDR) >> 2; address[1:0] ignored.
REQ-016 SHALL treat an address as out of range when address < BASE_ADDR or index >= DEPTH.
REQ-017 SHALL implement FSM states IDLE, WAIT, DONE; IDLE -> WAIT when (w_en|r_en)=1, counter loaded with LATENCY-1.
REQ-018 SHALL decrement the counter each WAIT cycle; WAIT -> DONE on the edge where the counter equals 0.
REQ-019 SHALL go DONE -> IDLE unconditionally on the next edge.
REQ-020 SHALL drive ready=1 only in DONE; an access requested in cycle 0 completes with ready=1 in cycle LATENCY+1.
REQ-021 SHALL perform the write, and load out with the read word, on the WAIT -> DONE edge, using inputs sampled on that edge.
REQ-022 SHALL require w_en, r_en, address and data to be held stable from request until ready; the block does not check this.
REQ-023 SHALL give the write priority when w_en=r_en=1: perform the write and leave out unchanged.
REQ-024 SHALL, for an out-of-range access: suppress the write, load out with 0 on a read, and set addr_err=1 in DONE.
REQ-025 SHALL hold out between reads; writes and idle cycles do not change out.
REQ-026 SHALL not start a new access in DONE; a back-to-back request is accepted in the following IDLE cycle.

Reset
REQ-027 SHALL on rst=1 force state IDLE, counter 0, out 0, ready 0, addr_err 0 at the next edge.
REQ-028 SHALL treat reset during WAIT as an abort: no memory write occurs and no ready pulse is issued.
REQ-029 SHALL not reset array contents; the array is undefined until written.

Structure
REQ-030 SHALL place the state encoding (IDLE=0, WAIT=1, DONE=2) and the default parameter constants in the shared package arm_mem_pkg.
REQ-031 SHALL instantiate a single storage sub-module, mem_array, with synchronous write and asynchronous read, DEPTH x DATA_W.
REQ-032 SHALL keep the FSM, counter, range check and output registers in data_mem_wait.

Verification (defaults, LATENCY=2)
REQ-033 SHALL cover this case: write 0xDEADBEEF to 0x404 at cycle 0, then read 0x404 -> ready=1 in cycles 3 and 7; out=0xDEADBEEF from cycle 7; addr_err=0.
REQ-034 SHALL cover this case: read 0x3FC, then read 0x500 (index 64) -> ready=1, addr_err=1, out=0 each time; array unchanged.
REQ-035 SHALL cover this case: w_en=r_en=1 at 0x408 with data 0x12345678 and prior out=0xA5 -> word 2 = 0x12345678; out stays 0xA5.
REQ-036 SHALL cover this case: rst=1 in cycle 1 of a write of 0x55 to 0x40C -> no ready pulse, out=0, later read of 0x40C does not return 0x55.
REQ-037 SHALL cover this case: address 0x407 written with 0x77, then read at 0x404 -> out=0x77 (low bits ignored).
REQ-038 SHALL cover this case: with LATENCY=1, back-to-back reads -> ready in cycles 2 and 5; ready is never high for 2 consecutive cycles.
